// File: rtl/irq_controller.sv
// Three-source nested interrupt controller: edge capture, fixed-priority arbitration
// against the in-service level, request/ack handshake and a per-level return PC stack.
module irq_controller #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [WIDTH-1:0] VEC_STRIDE = 32'h0000_0010
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       IRQ,
   input  logic             ie,
   input  logic             int_ack,
   input  logic             mret,
   input  logic [WIDTH-1:0] epc_in,
   output logic             int_req,
   output logic [WIDTH-1:0] int_vec,
   output logic [WIDTH-1:0] epc_out,
   output logic [2:0]       IRW,
   output logic [2:0]       pending
);

   typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [2:0]       irq_dly_q, irq_dly_d;
   logic [2:0]       pending_q, pending_d;
   logic [2:0]       irw_q, irw_d;
   logic [1:0]       req_id_q, req_id_d;
   logic [WIDTH-1:0] int_vec_q, int_vec_d;
   logic [WIDTH-1:0] epc_stack_q [0:2];
   logic [WIDTH-1:0] epc_stack_d [0:2];

   logic [2:0] edge_s;
   logic       cur_valid_s, cand_valid_s, eligible_s, take_s;
   logic [1:0] cur_idx_s, cand_idx_s;

   function automatic logic [WIDTH-1:0] vec_of(input logic [1:0] id);
      return VEC_BASE + ({{(WIDTH-2){1'b0}}, id} * VEC_STRIDE);
   endfunction

   // Highest in-service level and highest pending candidate
   always_comb begin
      cur_valid_s  = 1'b1;
      cur_idx_s    = 2'd0;
      cand_valid_s = 1'b1;
      cand_idx_s   = 2'd0;
      if (irw_q[2])      cur_idx_s = 2'd2;
      else if (irw_q[1]) cur_idx_s = 2'd1;
      else if (irw_q[0]) cur_idx_s = 2'd0;
      else               cur_valid_s = 1'b0;
      if (pending_q[2])      cand_idx_s = 2'd2;
      else if (pending_q[1]) cand_idx_s = 2'd1;
      else if (pending_q[0]) cand_idx_s = 2'd0;
      else                   cand_valid_s = 1'b0;
      eligible_s = ie & cand_valid_s & (~cur_valid_s | (cand_idx_s > cur_idx_s));
   end

   // Next-state logic for the handshake FSM, pending/in-service bits and PC stack
   always_comb begin
      state_d     = state_q;
      irq_dly_d   = IRQ;
      pending_d   = pending_q;
      irw_d       = irw_q;
      req_id_d    = req_id_q;
      int_vec_d   = int_vec_q;
      epc_stack_d = epc_stack_q;
      edge_s      = IRQ & ~irq_dly_q;
      take_s      = (state_q == REQ) & int_ack;

      case (state_q)
         IDLE: begin
            if (eligible_s) begin
               state_d   = REQ;
               req_id_d  = cand_idx_s;
               int_vec_d = vec_of(cand_idx_s);
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (int_ack)  state_d = IDLE;
            else if (!ie) state_d = IDLE;
            else          state_d = REQ;
         end
         default: state_d = IDLE;
      endcase

      // mret retires the old top level before the ack pushes the new one
      if (mret && cur_valid_s) irw_d[cur_idx_s] = 1'b0;
      else                     irw_d = irw_q;

      if (take_s) begin
         pending_d[req_id_q]   = 1'b0;
         irw_d[req_id_q]       = 1'b1;
         epc_stack_d[req_id_q] = epc_in;
      end else begin
         pending_d = pending_q;
      end

      pending_d = pending_d | edge_s;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         irq_dly_q <= 3'b000;
         pending_q <= 3'b000;
         irw_q     <= 3'b000;
         req_id_q  <= 2'd0;
         int_vec_q <= VEC_BASE;
         for (int i = 0; i < 3; i++) epc_stack_q[i] <= {WIDTH{1'b0}};
      end else begin
         state_q   <= state_d;
         irq_dly_q <= irq_dly_d;
         pending_q <= pending_d;
         irw_q     <= irw_d;
         req_id_q  <= req_id_d;
         int_vec_q <= int_vec_d;
         for (int i = 0; i < 3; i++) epc_stack_q[i] <= epc_stack_d[i];
      end
   end

   assign int_req = (state_q == REQ);
   assign int_vec = int_vec_q;
   assign IRW     = irw_q;
   assign pending = pending_q;
   assign epc_out = cur_valid_s ? epc_stack_q[cur_idx_s] : {WIDTH{1'b0}};

endmodule

// File: tb/tb_irq_controller.sv
// Table-driven bench for irq_controller: each row is one clock of stimulus plus the
// outputs expected after that edge, routed through a scoreboard queue.
module tb_irq_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  IRQ;
   logic        ie;
   logic        int_ack;
   logic        mret;
   logic [31:0] epc_in;
   logic        int_req;
   logic [31:0] int_vec;
   logic [31:0] epc_out;
   logic [2:0]  IRW;
   logic [2:0]  pending;

   irq_controller dut (
      .clk(clk), .rst(rst), .IRQ(IRQ), .ie(ie), .int_ack(int_ack), .mret(mret),
      .epc_in(epc_in), .int_req(int_req), .int_vec(int_vec), .epc_out(epc_out),
      .IRW(IRW), .pending(pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [2:0]  irq;
      logic        ie;
      logic        ack;
      logic        mret;
      logic [31:0] epc;
      logic        e_req;
      logic [31:0] e_vec;
      logic [2:0]  e_irw;
      logic [2:0]  e_pend;
      logic [31:0] e_epc;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic add(input logic r, input logic [2:0] irq, input logic e, input logic a,
                      input logic m, input logic [31:0] epc, input logic ereq,
                      input logic [31:0] evec, input logic [2:0] eirw,
                      input logic [2:0] epend, input logic [31:0] eepc);
      vec_t v;
      v.rst = r; v.irq = irq; v.ie = e; v.ack = a; v.mret = m; v.epc = epc;
      v.e_req = ereq; v.e_vec = evec; v.e_irw = eirw; v.e_pend = epend; v.e_epc = eepc;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int row, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input int row);
      vec_t e;
      @(negedge clk);
      rst = v.rst; IRQ = v.irq; ie = v.ie; int_ack = v.ack; mret = v.mret; epc_in = v.epc;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("int_req", row, {31'd0, int_req}, {31'd0, e.e_req});
      check("int_vec", row, int_vec, e.e_vec);
      check("IRW",     row, {29'd0, IRW}, {29'd0, e.e_irw});
      check("pending", row, {29'd0, pending}, {29'd0, e.e_pend});
      check("epc_out", row, epc_out, e.e_epc);
   endtask

   initial begin
      int n_edges;
      vec_t idle;
      rst = 1'b1; IRQ = 3'b000; ie = 1'b1; int_ack = 1'b0; mret = 1'b0; epc_in = 32'h0;

      //  rst irq    ie ack mret epc          req vec          irw     pend    epc_out
      // single request with stalled ack
      add(1, 3'b000, 1, 0, 0, 32'h0,    0, 32'h100, 3'b000, 3'b000, 32'h0);
      add(0, 3'b001, 1, 0, 0, 32'h0,    0, 32'h100, 3'b000, 3'b001, 32'h0);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h100, 3'b000, 3'b001, 32'h0);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h100, 3'b000, 3'b001, 32'h0);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h100, 3'b000, 3'b001, 32'h0);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h100, 3'b000, 3'b001, 32'h0);
      add(0, 3'b000, 1, 1, 0, 32'h40,   0, 32'h100, 3'b001, 3'b000, 32'h40);
      add(0, 3'b000, 1, 0, 0, 32'h0,    0, 32'h100, 3'b001, 3'b000, 32'h40);
      add(0, 3'b000, 1, 0, 1, 32'h0,    0, 32'h100, 3'b000, 3'b000, 32'h0);
      // nesting 0 then 2
      add(0, 3'b001, 1, 0, 0, 32'h0,    0, 32'h100, 3'b000, 3'b001, 32'h0);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h100, 3'b000, 3'b001, 32'h0);
      add(0, 3'b000, 1, 1, 0, 32'h40,   0, 32'h100, 3'b001, 3'b000, 32'h40);
      add(0, 3'b100, 1, 0, 0, 32'h0,    0, 32'h100, 3'b001, 3'b100, 32'h40);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h120, 3'b001, 3'b100, 32'h40);
      add(0, 3'b000, 1, 1, 0, 32'h104,  0, 32'h120, 3'b101, 3'b000, 32'h104);
      add(0, 3'b000, 1, 0, 1, 32'h0,    0, 32'h120, 3'b001, 3'b000, 32'h40);
      add(0, 3'b000, 1, 0, 1, 32'h0,    0, 32'h120, 3'b000, 3'b000, 32'h0);
      // priority and masking
      add(0, 3'b110, 1, 0, 0, 32'h0,    0, 32'h120, 3'b000, 3'b110, 32'h0);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h120, 3'b000, 3'b110, 32'h0);
      add(0, 3'b000, 1, 1, 0, 32'h200,  0, 32'h120, 3'b100, 3'b010, 32'h200);
      add(0, 3'b000, 1, 0, 0, 32'h0,    0, 32'h120, 3'b100, 3'b010, 32'h200);
      add(0, 3'b000, 1, 0, 1, 32'h0,    0, 32'h120, 3'b000, 3'b010, 32'h0);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h110, 3'b000, 3'b010, 32'h0);
      add(0, 3'b000, 1, 1, 0, 32'h300,  0, 32'h110, 3'b010, 3'b000, 32'h300);
      add(0, 3'b001, 1, 0, 0, 32'h0,    0, 32'h110, 3'b010, 3'b001, 32'h300);
      add(0, 3'b000, 1, 0, 0, 32'h0,    0, 32'h110, 3'b010, 3'b001, 32'h300);
      add(0, 3'b000, 1, 0, 1, 32'h0,    0, 32'h110, 3'b000, 3'b001, 32'h0);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h100, 3'b000, 3'b001, 32'h0);
      add(0, 3'b000, 1, 1, 0, 32'h50,   0, 32'h100, 3'b001, 3'b000, 32'h50);
      add(0, 3'b000, 1, 0, 1, 32'h0,    0, 32'h100, 3'b000, 3'b000, 32'h0);
      // enable withdrawal
      add(0, 3'b010, 1, 0, 0, 32'h0,    0, 32'h100, 3'b000, 3'b010, 32'h0);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h110, 3'b000, 3'b010, 32'h0);
      add(0, 3'b000, 0, 0, 0, 32'h0,    0, 32'h110, 3'b000, 3'b010, 32'h0);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h110, 3'b000, 3'b010, 32'h0);
      add(0, 3'b000, 1, 1, 0, 32'h60,   0, 32'h110, 3'b010, 3'b000, 32'h60);
      add(0, 3'b000, 1, 0, 1, 32'h0,    0, 32'h110, 3'b000, 3'b000, 32'h0);
      // edge on 0 colliding with ack of 0
      add(0, 3'b001, 1, 0, 0, 32'h0,    0, 32'h110, 3'b000, 3'b001, 32'h0);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h100, 3'b000, 3'b001, 32'h0);
      add(0, 3'b001, 1, 1, 0, 32'h70,   0, 32'h100, 3'b001, 3'b001, 32'h70);
      add(0, 3'b000, 1, 0, 0, 32'h0,    0, 32'h100, 3'b001, 3'b001, 32'h70);
      add(0, 3'b000, 1, 0, 1, 32'h0,    0, 32'h100, 3'b000, 3'b001, 32'h0);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h100, 3'b000, 3'b001, 32'h0);
      add(0, 3'b000, 1, 1, 0, 32'h74,   0, 32'h100, 3'b001, 3'b000, 32'h74);
      add(0, 3'b000, 1, 0, 1, 32'h0,    0, 32'h100, 3'b000, 3'b000, 32'h0);
      // mret and ack of source 2 together while IRW=010
      add(0, 3'b010, 1, 0, 0, 32'h0,    0, 32'h100, 3'b000, 3'b010, 32'h0);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h110, 3'b000, 3'b010, 32'h0);
      add(0, 3'b000, 1, 1, 0, 32'h80,   0, 32'h110, 3'b010, 3'b000, 32'h80);
      add(0, 3'b100, 1, 0, 0, 32'h0,    0, 32'h110, 3'b010, 3'b100, 32'h80);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h120, 3'b010, 3'b100, 32'h80);
      add(0, 3'b000, 1, 1, 1, 32'h90,   0, 32'h120, 3'b100, 3'b000, 32'h90);
      add(0, 3'b000, 1, 0, 1, 32'h0,    0, 32'h120, 3'b000, 3'b000, 32'h0);
      // ack while idle is ignored
      add(0, 3'b000, 1, 1, 0, 32'hAA,   0, 32'h120, 3'b000, 3'b000, 32'h0);
      // reset during REQ with IRW=011 and IRQ[1] held high
      add(0, 3'b001, 1, 0, 0, 32'h0,    0, 32'h120, 3'b000, 3'b001, 32'h0);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h100, 3'b000, 3'b001, 32'h0);
      add(0, 3'b000, 1, 1, 0, 32'h10,   0, 32'h100, 3'b001, 3'b000, 32'h10);
      add(0, 3'b010, 1, 0, 0, 32'h0,    0, 32'h100, 3'b001, 3'b010, 32'h10);
      add(0, 3'b000, 1, 0, 0, 32'h0,    1, 32'h110, 3'b001, 3'b010, 32'h10);
      add(0, 3'b000, 1, 1, 0, 32'h20,   0, 32'h110, 3'b011, 3'b000, 32'h20);
      add(0, 3'b100, 1, 0, 0, 32'h0,    0, 32'h110, 3'b011, 3'b100, 32'h20);
      add(0, 3'b010, 1, 0, 0, 32'h0,    1, 32'h120, 3'b011, 3'b110, 32'h20);
      add(1, 3'b010, 1, 0, 0, 32'h0,    0, 32'h100, 3'b000, 3'b000, 32'h0);
      add(0, 3'b010, 1, 0, 0, 32'h0,    0, 32'h100, 3'b000, 3'b010, 32'h0);
      add(0, 3'b010, 1, 0, 0, 32'h0,    1, 32'h110, 3'b000, 3'b010, 32'h0);
      add(0, 3'b000, 1, 1, 0, 32'h5,    0, 32'h110, 3'b010, 3'b000, 32'h5);
      add(0, 3'b000, 1, 0, 1, 32'h0,    0, 32'h110, 3'b000, 3'b000, 32'h0);

      foreach (vecs[i]) step(vecs[i], i);

      // Hand-written latency check: a one-cycle pulse on IRQ[2] must raise int_req on
      // the second edge after it is driven; the wait is bounded.
      @(negedge clk);
      IRQ = 3'b100; int_ack = 1'b0; mret = 1'b0;
      @(negedge clk);
      IRQ = 3'b000;
      n_edges = 1;
      while (!int_req && n_edges < 8) begin
         @(posedge clk);
         #1;
         n_edges++;
      end
      check("req_latency_edges", 0, n_edges, 32'd2);
      check("req_latency_vec", 0, int_vec, 32'h120);
      idle.rst = 1'b0; idle.irq = 3'b000; idle.ie = 1'b1; idle.ack = 1'b1; idle.mret = 1'b0;
      idle.epc = 32'h1234; idle.e_req = 1'b0; idle.e_vec = 32'h120; idle.e_irw = 3'b100;
      idle.e_pend = 3'b000; idle.e_epc = 32'h1234;
      step(idle, 1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit so the run always terminates
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected $finish before 100000");
      $fatal(1);
   end

endmodule

// File: doc/irq_controller.md
# irq_controller

Three-source nested interrupt controller sitting between the board/testbench `IRQ[2:0]` lines and the pipelined CPU. It performs these functions:
- Detects request edges and holds them as pending.
- Arbitrates by fixed priority against the currently in-service level.
- Presents one request with its handler vector to the pipeline until it is taken.
- Saves and restores one return PC per level, supporting up to three nested levels.

It drives the `IRW` in-service indicators.

## Interface
- `WIDTH`, 32, PC/vector width
- `VEC_BASE`, 32'h0000_0100, handler address of source 0
- `VEC_STRIDE`, 32'h0000_0010, address distance between consecutive handlers
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `IRQ`  in  3  raw request lines; rising edge = one request; bit 2 highest priority
- `ie`  in  1  global interrupt enable from CPU status
- `int_ack`  in  1  pipeline has flushed and redirected to `int_vec` this cycle
- `mret`  in  1  handler return retiring this cycle (one-cycle pulse)
- `epc_in`  in  WIDTH  PC to resume after the handler, valid with `int_ack`
- `int_req`  out  1  request to pipeline
- `int_vec`  out  WIDTH  handler address for the requested source
- `epc_out`  out  WIDTH  return PC of the highest in-service level (0 if none)
- `IRW`  out  3  in-service bits
- `pending`  out  3  latched, not-yet-taken requests

## Operation
- Edge detect: register `irq_d <= IRQ`. A rising edge on source i is `IRQ[i] & ~irq_d[i]` and sets `pending[i]`.
- Level model:
  - `cur` = index of the highest set `IRW` bit, or "none" (below 0).
  - `cand` = highest set `pending` bit.
  - `eligible` = `ie & (pending != 0) & (cand > cur)`.
- FSM with two states, `IDLE` and `REQ`:
  - `IDLE` → `REQ` when `eligible`. On that edge, `req_id <= cand` is latched.
  - `REQ` holds `req_id` stable. A higher-priority edge arriving during `REQ` does not change `req_id`; it is served after the ack.
  - `REQ` + `int_ack` → `IDLE`. Clear `pending[req_id]`, set `IRW[req_id]`, and store `epc_stack[req_id] <= epc_in`.
  - `REQ` + `ie`=0 + no `int_ack` → `IDLE`. The request is withdrawn and the pending bit is kept.
  - `int_ack` while `IDLE` is ignored.
- `int_req` = (state == `REQ`).
- `int_vec` = `VEC_BASE + req_id*VEC_STRIDE`, truncated to WIDTH. It is driven in both states and valid while `int_req`=1.
- `mret` clears `IRW[cur]` using the pre-edge `IRW` value. `mret` with `IRW`=0 is ignored.
- `epc_out` = `epc_stack[cur]`, combinational from registered state.
- Simultaneous events:
  - Edge on i in the same cycle as ack of i: the set wins, and `pending[i]` stays 1.
  - `mret` and `int_ack` in the same cycle: both apply. `mret` clears the old `cur` bit and the ack sets the `req_id` bit.
  - Edge on i while `IRW[i]`=1: `pending[i]` is set and becomes eligible only after that level returns.
  - Repeated edges on one source before it is taken merge into one pending request.

## Timing
- Reset values:
  - `pending`, `IRW`, `irq_d`, `req_id`, and all `epc_stack` entries are 0.
  - State is `IDLE` and `int_req` is 0.
  - `int_vec` = `VEC_BASE`.
  - `epc_out` = 0.
- An `IRQ` line already high at reset release counts as an edge on the first post-reset edge, because `irq_d` resets to 0.
- Latency:
  - `IRQ[i]` first sampled high at edge k → `pending[i]`=1 after k.
  - `int_req`=1 after k+1, provided the source is eligible.
- Handshake:
  - `int_req` stays high with a constant `int_vec` until the edge where `int_ack`=1.
  - `int_req` is low after that edge, and `IRW` is updated after that same edge.
- Nested re-request:
  - The earliest next `int_req` is one cycle after the ack edge; the FSM spends at least one cycle in `IDLE`.
  - After `mret` re-opens a lower pending level, `int_req` rises one edge after `mret`.
- `rst` mid-`REQ` or mid-handler: all state clears on that edge, with no ack or epc retained.

## Test plan
- Single request, with `ie`=1:
  - Stimulus: pulse `IRQ[0]` for 1 cycle.
  - Required: `int_req` high 2 edges later with `int_vec`=0x100. Hold `int_ack` off for 3 cycles → `int_req` and `int_vec` stay stable.
  - Ack with `epc_in`=0x40 → `IRW`=001 and `epc_out`=0x40.
  - `mret` → `IRW`=000 and `epc_out`=0.
- Nesting:
  - Stimulus: `IRQ[0]` taken (epc 0x40), then `IRQ[2]` taken (epc 0x104).
  - Required: `IRW`=101, `int_vec`=0x120, `epc_out`=0x104.
  - `mret` → `IRW`=001 and `epc_out`=0x40.
- Priority and masking:
  - Stimulus: `IRQ[1]` and `IRQ[2]` edges in the same cycle.
  - Required: `int_vec`=0x120 first; after its ack, `int_req` is low because 1 < 2.
  - After `mret`, `int_req` rises with `int_vec`=0x110.
  - An edge on `IRQ[0]` while `IRW`=010 sets `pending`=001 and leaves `int_req` low.
- Enable withdrawal:
  - Stimulus: `IRQ[1]` edge, `int_req` high, then `ie`=0 for 1 cycle.
  - Required: `int_req` low next edge with `pending`=010 kept. `ie`=1 → `int_req` re-asserts.
- Collisions:
  - Stimulus: edge on `IRQ[0]` in the same cycle as `int_ack` of source 0.
  - Required: `IRW`=001 and `pending`=001.
  - Stimulus: `mret` and `int_ack` (source 2) in the same cycle with `IRW`=010.
  - Required: `IRW`=100.
- Reset mid-operation:
  - Stimulus: assert `rst` with `int_req`=1 and `IRW`=011, while `IRQ[1]` is held high.
  - Required: all outputs return to their reset values.
  - After `rst` drops, `pending`=010 one edge later (edge from `irq_d`=0).
